// File: rtl/snd_dma_ctrl_pkg.sv
// Shared types and constants for the sound DMA controller.
`timescale 1ns/1ps
package snd_dma_ctrl_pkg;

    localparam int unsigned ADDR_W   = 21;
    localparam int unsigned CTL_W    = 2;
    localparam int unsigned CTL_EN   = 0;
    localparam int unsigned CTL_LOOP = 1;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        WAIT = 3'd2,
        REQ  = 3'd3,
        ADV  = 3'd4
    } state_e;

endpackage

// File: rtl/snd_dma_ctrl_if.sv
// Host register writes, FIFO/bus handshake and status of the sound DMA controller.
`timescale 1ns/1ps
interface snd_dma_ctrl_if;
    import snd_dma_ctrl_pkg::*;

    logic             ctl_we;
    logic [CTL_W-1:0] ctl_wdata;
    logic             start_we;
    logic             end_we;
    addr_t            addr_wdata;
    logic             fifo_req;
    logic             dma_ack;

    logic             dma_req;
    addr_t            snd;
    logic             sint;
    logic             active;
    logic [CTL_W-1:0] ctl_rdata;

    // Host / bus side
    modport master (
        output ctl_we, ctl_wdata, start_we, end_we, addr_wdata, fifo_req, dma_ack,
        input  dma_req, snd, sint, active, ctl_rdata
    );

    // Controller side
    modport slave (
        input  ctl_we, ctl_wdata, start_we, end_we, addr_wdata, fifo_req, dma_ack,
        output dma_req, snd, sint, active, ctl_rdata
    );

endinterface

// File: rtl/snd_addr_cnt.sv
// Frame word address register: load with the frame start, step by one word.
`timescale 1ns/1ps
module snd_addr_cnt
    import snd_dma_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clr_n,
    input  logic  load,
    input  logic  inc,
    input  addr_t load_val,
    output addr_t addr_q,
    output addr_t addr_inc_c
);

    addr_t addr_d;

    // Wrapping increment, also used by the controller for the end compare
    assign addr_inc_c = addr_q + ADDR_W'(1);

    // Next address: soft clear, then load, then increment
    always_comb begin
        addr_d = addr_q;
        if (!clr_n) begin
            addr_d = '0;
        end else if (load) begin
            addr_d = load_val;
        end else if (inc) begin
            addr_d = addr_inc_c;
        end
    end

    // Address register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/snd_dma_ctrl.sv
// Sound DMA controller: walks a double-buffered frame of word addresses,
// one bus request per FIFO slot, with optional looping and frame-end pulse.
`timescale 1ns/1ps
module snd_dma_ctrl
    import snd_dma_ctrl_pkg::*;
(
    input  logic          sndclk,
    input  logic          porb,
    input  logic          lresb,
    snd_dma_ctrl_if.slave bus
);

    state_e state_q, state_d;
    addr_t  start_q, start_d;
    addr_t  end_q, end_d;
    addr_t  end_lat_q, end_lat_d;
    logic   en_q, en_d;
    logic   loop_q, loop_d;
    logic   dma_req_q, dma_req_d;
    logic   sint_q, sint_d;
    logic   active_q, active_d;

    logic   cnt_load;
    logic   cnt_inc;
    logic   frame_end;
    addr_t  snd_q;
    addr_t  snd_inc_c;

    snd_addr_cnt u_addr_cnt (
        .clk        (sndclk),
        .rst_n      (porb),
        .clr_n      (lresb),
        .load       (cnt_load),
        .inc        (cnt_inc),
        .load_val   (start_q),
        .addr_q     (snd_q),
        .addr_inc_c (snd_inc_c)
    );

    // Next state, register updates and look-ahead for the registered outputs
    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        end_d     = end_q;
        end_lat_d = end_lat_q;
        en_d      = en_q;
        loop_d    = loop_q;
        cnt_load  = 1'b0;
        cnt_inc   = 1'b0;
        frame_end = 1'b0;

        if (bus.start_we) start_d = bus.addr_wdata;
        if (bus.end_we)   end_d   = bus.addr_wdata;

        case (state_q)
            IDLE: begin
                if (en_q) state_d = LOAD;
            end
            LOAD: begin
                cnt_load  = 1'b1;
                end_lat_d = end_q;
                if (start_q == end_q) frame_end = 1'b1;
                else                  state_d   = WAIT;
            end
            WAIT: begin
                if (!en_q)             state_d = IDLE;
                else if (bus.fifo_req) state_d = REQ;
            end
            REQ: begin
                if (bus.dma_ack) state_d = ADV;
            end
            ADV: begin
                if (snd_inc_c == end_lat_q) begin
                    frame_end = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                    state_d = en_q ? WAIT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame end: restart only if looping and the host has not disabled us
        if (frame_end) begin
            if (loop_q && en_q) begin
                state_d = LOAD;
            end else begin
                en_d    = 1'b0;
                state_d = IDLE;
            end
        end

        // A host control write overrides the automatic enable clear
        if (bus.ctl_we) begin
            en_d   = bus.ctl_wdata[CTL_EN];
            loop_d = bus.ctl_wdata[CTL_LOOP];
        end

        if (!lresb) begin
            state_d   = IDLE;
            start_d   = '0;
            end_d     = '0;
            end_lat_d = '0;
            en_d      = 1'b0;
            loop_d    = 1'b0;
            cnt_load  = 1'b0;
            cnt_inc   = 1'b0;
        end

        // sint is high during the LOAD or ADV cycle that ends the frame
        dma_req_d = (state_d == REQ);
        active_d  = (state_d != IDLE);
        sint_d    = ((state_d == LOAD) && (start_d == end_d)) ||
                    ((state_d == ADV)  && (snd_inc_c == end_lat_q));
    end

    // State and register bank
    always_ff @(posedge sndclk or negedge porb) begin
        if (!porb) begin
            state_q   <= IDLE;
            start_q   <= '0;
            end_q     <= '0;
            end_lat_q <= '0;
            en_q      <= 1'b0;
            loop_q    <= 1'b0;
            dma_req_q <= 1'b0;
            sint_q    <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            end_q     <= end_d;
            end_lat_q <= end_lat_d;
            en_q      <= en_d;
            loop_q    <= loop_d;
            dma_req_q <= dma_req_d;
            sint_q    <= sint_d;
            active_q  <= active_d;
        end
    end

    assign bus.dma_req   = dma_req_q;
    assign bus.snd       = snd_q;
    assign bus.sint      = sint_q;
    assign bus.active    = active_q;
    assign bus.ctl_rdata = {loop_q, en_q};

endmodule
